// File: rtl/uart_rx_pkg.sv
// Shared definitions for the uart_rx block: register map, CTRL/STATUS bit
// positions, receiver FSM encoding, prescaler reset/minimum and FIFO depth.
// The buffer style is selected in uart_rx by the UART_RX_FIFO_EN macro.
package uart_rx_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned STRB_W  = 4;
  localparam int unsigned PRESC_W = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned BIT_IDX_W = 3;

  // Register byte offsets
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 5'h00;
  localparam logic [ADDR_W-1:0] ADDR_PRESC  = 5'h04;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 5'h08;
  localparam logic [ADDR_W-1:0] ADDR_RXDATA = 5'h0C;

  // CTRL bit positions
  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_FLUSH  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  // STATUS bit positions
  localparam int unsigned STAT_NOT_EMPTY = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVERRUN   = 2;
  localparam int unsigned STAT_FRAME_ERR = 3;

  // Prescaler reset value and the smallest bit period the receiver uses
  localparam logic [PRESC_W-1:0] PRESC_RESET = 16'd16;
  localparam logic [PRESC_W-1:0] PRESC_MIN   = 16'd4;

  // Receive FIFO depth when the FIFO build is selected
  localparam int unsigned FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Bit period actually used by the receiver (small values are clamped)
  function automatic logic [PRESC_W-1:0] eff_presc(input logic [PRESC_W-1:0] p);
    return (p < PRESC_MIN) ? PRESC_MIN : p;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO used as the receive buffer: push/pop/flush with
// full/empty flags. A pop frees a slot in the same cycle, so a simultaneous
// push into a full FIFO is accepted.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Pointer advance with explicit wrap so any depth works
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Occupancy flags and accepted-operation qualifiers
  always_comb begin
    full_c  = (count == CW'(DEPTH));
    empty_c = (count == '0);
    do_pop  = pop & ~empty_c;
    do_push = push & (~full_c | do_pop);
    head_c  = mem[rd_ptr];
  end

  // Storage write; flush takes precedence over a same-cycle push
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, LSB first) with a small register bus.
// Build option: define UART_RX_FIFO_EN for an 8-entry receive FIFO;
// otherwise a single holding register is used (full whenever not empty).
module uart_rx
  import uart_rx_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              select,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready,
  output logic [DATA_W-1:0] data_o,
  input  logic              rx,
  output logic              irq
);

  // Configuration and status registers
  logic               enable;
  logic               irq_en;
  logic [PRESC_W-1:0] presc;
  logic               overrun;
  logic               frame_err;

  // Bus handshake
  logic               done;
  logic               access_c;
  logic               wr_c;
  logic               rd_c;
  logic [DATA_W-1:0]  rdata_c;

  // Serial input conditioning
  logic               rx_meta;
  logic               rx_sync;
  logic               rx_prev;
  logic               fall_c;

  // Receiver FSM and datapath
  rx_state_e            state;
  rx_state_e            state_next;
  logic [PRESC_W-1:0]   cnt;
  logic [PRESC_W-1:0]   period_c;
  logic [PRESC_W-1:0]   half_m1_c;
  logic [PRESC_W-1:0]   full_m1_c;
  logic                 tick_c;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [BYTE_W-1:0]    shift;
  logic                 push_c;
  logic                 ferr_c;

  // Receive buffer interface
  logic              pop_c;
  logic              flush_c;
  logic              ovr_set_c;
  logic [BYTE_W-1:0] buf_head;
  logic              buf_full;
  logic              buf_empty;

  logic unused_bits;
  assign unused_bits = ^data_i[DATA_W-1:PRESC_W];

  // Bus decode: one access per select assertion
  always_comb begin
    access_c  = select & ~done;
    wr_c      = access_c & (|wstrb);
    rd_c      = access_c & ~(|wstrb);
    pop_c     = rd_c & (addr == ADDR_RXDATA);
    flush_c   = wr_c & (addr == ADDR_CTRL) & wstrb[0] & data_i[CTRL_FLUSH];
    ovr_set_c = push_c & buf_full & ~pop_c;
  end

  // Read data mux; flush always reads back as 0
  always_comb begin
    rdata_c = '0;
    case (addr)
      ADDR_CTRL:   rdata_c = {29'b0, irq_en, 1'b0, enable};
      ADDR_PRESC:  rdata_c = {16'b0, presc};
      ADDR_STATUS: rdata_c = {28'b0, frame_err, overrun, buf_full, ~buf_empty};
      ADDR_RXDATA: rdata_c = buf_empty ? '0 : {24'b0, buf_head};
      default:     rdata_c = '0;
    endcase
  end

  // Ready pulse, read data and the re-arm flag that waits for select low
  always_ff @(posedge clk) begin
    if (reset) begin
      ready  <= 1'b0;
      data_o <= '0;
      done   <= 1'b0;
    end else begin
      ready  <= access_c;
      data_o <= access_c ? rdata_c : '0;
      if (!select) begin
        done <= 1'b0;
      end else if (access_c) begin
        done <= 1'b1;
      end
    end
  end

  // Register writes (byte-lane masked) and sticky error flags with W1C
  always_ff @(posedge clk) begin
    if (reset) begin
      enable    <= 1'b0;
      irq_en    <= 1'b0;
      presc     <= PRESC_RESET;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_c && addr == ADDR_CTRL && wstrb[0]) begin
        enable <= data_i[CTRL_ENABLE];
        irq_en <= data_i[CTRL_IRQ_EN];
      end
      if (wr_c && addr == ADDR_PRESC) begin
        if (wstrb[0]) presc[7:0]  <= data_i[7:0];
        if (wstrb[1]) presc[15:8] <= data_i[15:8];
      end
      if (wr_c && addr == ADDR_STATUS && wstrb[0]) begin
        overrun   <= (overrun & ~data_i[STAT_OVERRUN]) | ovr_set_c;
        frame_err <= (frame_err & ~data_i[STAT_FRAME_ERR]) | ferr_c;
      end else begin
        overrun   <= overrun | ovr_set_c;
        frame_err <= frame_err | ferr_c;
      end
    end
  end

  // Interrupt: data available and enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en & ~buf_empty;
    end
  end

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Bit timing: half period in START, full period in DATA/STOP
  always_comb begin
    fall_c    = rx_prev & ~rx_sync;
    period_c  = eff_presc(presc);
    half_m1_c = (period_c >> 1) - PRESC_W'(1);
    full_m1_c = period_c - PRESC_W'(1);
    if (state == ST_IDLE) begin
      tick_c = 1'b0;
    end else if (state == ST_START) begin
      tick_c = (cnt == half_m1_c);
    end else begin
      tick_c = (cnt == full_m1_c);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; dropping enable aborts any frame in progress
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (fall_c) state_next = ST_START;
        ST_START: if (tick_c) state_next = rx_sync ? ST_IDLE : ST_DATA;
        ST_DATA:  if (tick_c && bit_idx == BIT_IDX_W'(7)) state_next = ST_STOP;
        ST_STOP:  if (tick_c) state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: stop-bit verdict
  always_comb begin
    push_c = 1'b0;
    ferr_c = 1'b0;
    if (state == ST_STOP && enable && tick_c) begin
      if (rx_sync) begin
        push_c = 1'b1;
      end else begin
        ferr_c = 1'b1;
      end
    end
  end

  // Receive datapath: period counter, bit index and LSB-first shifter
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (state == ST_IDLE || state_next != state || tick_c) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + PRESC_W'(1);
      end
      if (state != ST_DATA) begin
        bit_idx <= '0;
      end else if (tick_c) begin
        bit_idx <= bit_idx + BIT_IDX_W'(1);
      end
      if (state == ST_DATA && tick_c) begin
        shift <= {rx_sync, shift[BYTE_W-1:1]};
      end
    end
  end

`ifdef UART_RX_FIFO_EN
  uart_rx_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (shift),
    .pop       (pop_c),
    .flush     (flush_c),
    .head_c    (buf_head),
    .full_c    (buf_full),
    .empty_c   (buf_empty)
  );
`else
  logic              hold_valid;
  logic [BYTE_W-1:0] hold_data;

  // Single holding register; a pop frees it for a same-cycle push
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (flush_c) begin
      hold_valid <= 1'b0;
    end else if (push_c && (!hold_valid || pop_c)) begin
      hold_valid <= 1'b1;
      hold_data  <= shift;
    end else if (pop_c) begin
      hold_valid <= 1'b0;
    end
  end

  assign buf_head  = hold_data;
  assign buf_full  = hold_valid;
  assign buf_empty = ~hold_valid;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx; expectations follow the build option
// UART_RX_FIFO_EN (FIFO) or its absence (single holding register).
module tb_uart_rx;

  localparam int unsigned P = 10;
  localparam logic [4:0] A_CTRL   = 5'h00;
  localparam logic [4:0] A_PRESC  = 5'h04;
  localparam logic [4:0] A_STATUS = 5'h08;
  localparam logic [4:0] A_RXDATA = 5'h0C;

`ifdef UART_RX_FIFO_EN
  localparam logic [31:0] ONE_BYTE_STATUS = 32'h1;
`else
  localparam logic [31:0] ONE_BYTE_STATUS = 32'h3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        select;
  logic [3:0]  wstrb;
  logic [4:0]  addr;
  logic [31:0] data_i;
  logic        ready;
  logic [31:0] data_o;
  logic        rx;
  logic        irq;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q;
  int          pulses;

  uart_rx dut (
    .clk    (clk),
    .reset  (reset),
    .select (select),
    .wstrb  (wstrb),
    .addr   (addr),
    .data_i (data_i),
    .ready  (ready),
    .data_o (data_o),
    .rx     (rx),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] r);
    select = 1'b1;
    addr   = a;
    wstrb  = s;
    data_i = d;
    step();
    check("bus_ready", {31'b0, ready}, 32'h1);
    r = data_o;
    select = 1'b0;
    wstrb  = 4'h0;
    data_i = '0;
    step();
  endtask

  task automatic wr(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] dummy;
    bus(a, s, d, dummy);
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(a, 4'h0, '0, r);
    check(tag, r, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int unsigned p);
    rx = 1'b0;
    repeat (p) step();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (p) step();
    end
    rx = stop;
    repeat (p) step();
    rx = 1'b1;
    repeat (2 * p + 4) step();
  endtask

  initial begin
    reset  = 1'b1;
    select = 1'b0;
    wstrb  = 4'h0;
    addr   = '0;
    data_i = '0;
    rx     = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_data_o", data_o, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rd_check("rst_ctrl", A_CTRL, 32'h0);
    rd_check("rst_presc", A_PRESC, 32'h10);
    rd_check("rst_status", A_STATUS, 32'h0);

    // Byte-lane write to PRESC
    wr(A_PRESC, 4'b0001, 32'h0000_1234);
    rd_check("presc_lane0", A_PRESC, 32'h34);

    // Single ready pulse while select stays high
    select = 1'b1;
    addr   = A_STATUS;
    wstrb  = 4'h0;
    pulses = 0;
    repeat (5) begin
      step();
      if (ready) pulses++;
    end
    select = 1'b0;
    step();
    check("ready_single", 32'(pulses), 32'h1);

    // Basic reception
    wr(A_PRESC, 4'b0011, P);
    wr(A_CTRL, 4'b0001, 32'h1);
    rd_check("ctrl_en", A_CTRL, 32'h1);
    send_byte(8'h61, 1'b1, P);
    rd_check("rx61_status", A_STATUS, ONE_BYTE_STATUS);
    rd_check("rx61_data", A_RXDATA, 32'h61);
    rd_check("rx61_status_after", A_STATUS, 32'h0);

    // Empty pop and unmapped offset
    rd_check("empty_rxdata", A_RXDATA, 32'h0);
    rd_check("empty_status", A_STATUS, 32'h0);
    wr(5'h14, 4'hF, 32'hFFFF_FFFF);
    rd_check("unmapped", 5'h10, 32'h0);

    // Short glitch on the line
    rx = 1'b0;
    repeat (3) step();
    rx = 1'b1;
    repeat (40) step();
    rd_check("glitch_status", A_STATUS, 32'h0);

    // Framing error and W1C clear
    send_byte(8'h55, 1'b0, P);
    rd_check("ferr_status", A_STATUS, 32'h8);
    wr(A_STATUS, 4'b0001, 32'h8);
    rd_check("ferr_cleared", A_STATUS, 32'h0);

    // Interrupt and flush
    wr(A_CTRL, 4'b0001, 32'h5);
    send_byte(8'h3C, 1'b1, P);
    check("irq_set", {31'b0, irq}, 32'h1);
    wr(A_CTRL, 4'b0001, 32'h7);
    rd_check("flush_status", A_STATUS, 32'h0);
    rd_check("flush_ctrl", A_CTRL, 32'h5);
    check("irq_clear", {31'b0, irq}, 32'h0);

    // Overrun
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1, P);
    rd_check("ovr_status", A_STATUS, 32'h7);
    for (int i = 1; i <= 8; i++) rd_check("fifo_order", A_RXDATA, 32'(i));
`else
    send_byte(8'h01, 1'b1, P);
    send_byte(8'h02, 1'b1, P);
    rd_check("ovr_status", A_STATUS, 32'h7);
    rd_check("ovr_kept", A_RXDATA, 32'h01);
`endif
    rd_check("ovr_sticky", A_STATUS, 32'h4);
    wr(A_STATUS, 4'b0001, 32'h4);
    rd_check("ovr_cleared", A_STATUS, 32'h0);

    // Clamped prescaler
    wr(A_PRESC, 4'b0011, 32'h2);
    send_byte(8'h96, 1'b1, 4);
    rd_check("presc_clamp", A_RXDATA, 32'h96);
    wr(A_PRESC, 4'b0011, P);

    // Disable in mid-frame
    rx = 1'b0;
    repeat (P) step();
    rx = 1'b1;
    repeat (2 * P) step();
    wr(A_CTRL, 4'b0001, 32'h0);
    repeat (100) step();
    rd_check("disable_status", A_STATUS, 32'h0);
    wr(A_CTRL, 4'b0001, 32'h1);
    send_byte(8'hA7, 1'b1, P);
    rd_check("reenable_data", A_RXDATA, 32'hA7);

    // Reset during DATA of 0xA5
    rx = 1'b0;
    repeat (P) step();
    rx = 1'b1; repeat (P) step();
    rx = 1'b0; repeat (P) step();
    rx = 1'b1; repeat (P) step();
    reset = 1'b1;
    repeat (2) step();
    rx = 1'b1;
    reset = 1'b0;
    repeat (30) step();
    rd_check("midrst_status", A_STATUS, 32'h0);
    rd_check("midrst_presc", A_PRESC, 32'h10);
    wr(A_PRESC, 4'b0011, P);
    wr(A_CTRL, 4'b0001, 32'h1);
    send_byte(8'h3C, 1'b1, P);
    rd_check("midrst_next", A_RXDATA, 32'h3C);
    rd_check("midrst_final", A_STATUS, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have one clock, clk; reset is synchronous and active-high.
REQ-002 SHALL expose ports: clk  in  1  system clock; reset  in  1  sync active-high reset; select  in  1  bus select; wstrb  in  4  byte write strobes (0 = read); addr  in  5  byte offset; data_i  in  32  write data; ready  out  1  transfer done; data_o  out  32  read data; rx  in  1  serial line (idle high); irq  out  1  data-available interrupt.
REQ-003 SHALL decode registers: 0x00 CTRL (bit0 enable, bit1 flush, bit2 irq_en); 0x04 PRESC (bits15:0 clocks per bit); 0x08 STATUS (bit0 not_empty, bit1 full, bit2 overrun, bit3 frame_err); 0x0C RXDATA (bits7:0, read pops); other offsets read 0, writes ignored.

Function
REQ-004 SHALL assert ready for exactly one cycle, the cycle after select is sampled high; it SHALL not re-assert until select has been low for at least one cycle.
REQ-005 SHALL drive data_o valid in the ready cycle, 0 otherwise.
REQ-006 SHALL apply writes only to byte lanes with wstrb set.
REQ-007 SHALL pass rx through a two-flop synchronizer before any use.
REQ-008 SHALL run FSM IDLE -> START -> DATA -> STOP -> IDLE, 8N1, LSB first.
REQ-009 IDLE: SHALL leave on a synchronized 1->0 transition only when CTRL.enable = 1.
REQ-010 START: SHALL wait PRESC/2 clocks, then sample; 0 -> DATA, 1 -> IDLE (glitch, no flags).
REQ-011 DATA: SHALL sample every PRESC clocks, 8 samples, then go to STOP.
REQ-012 STOP: after PRESC clocks, sample; 1 -> push byte; 0 -> set frame_err, drop byte; both -> IDLE.
REQ-013 SHALL treat PRESC values below 4 as 4.
REQ-014 Push when full: SHALL drop the byte and set sticky overrun; stored bytes unchanged.
REQ-015 Push and pop in the same cycle SHALL both succeed, with no overrun even when full.
REQ-016 RXDATA read when empty SHALL return 0 and SHALL not change state.
REQ-017 Writing 1 to STATUS bit2/bit3 SHALL clear that flag (W1C); bits 0/1 are read-only.
REQ-018 A CTRL.flush write SHALL empty the buffer in one cycle; flush is self-clearing and reads 0.
REQ-019 Clearing CTRL.enable mid-frame SHALL return the FSM to IDLE next cycle and discard the partial byte.
REQ-020 irq SHALL be registered and equal irq_en AND not_empty.

Reset
REQ-021 On reset SHALL set: FSM IDLE, buffer empty, CTRL = 0, PRESC = 16, flags 0, ready 0, data_o 0, irq 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no push and no flag.

Configuration
REQ-023 With UART_RX_FIFO_EN defined, buffer SHALL be an 8-entry FIFO; full = 8 entries.
REQ-024 Without UART_RX_FIFO_EN, buffer SHALL be a single holding register; full = not_empty.

Structure
REQ-025 A shared package SHALL hold register offsets, STATUS/CTRL bit indices, FSM state encoding, PRESC reset value and FIFO depth.
REQ-026 The FIFO SHALL be a sub-module uart_rx_fifo (parameterized width/depth, push/pop/flush, full/empty); the FSM and bus logic stay in uart_rx.

Verification
REQ-027 PRESC=10, enable=1, send 0x61 -> STATUS=0x1, RXDATA reads 0x61, STATUS then 0x0.
REQ-028 rx low 3 clocks then high, PRESC=10 -> no push, STATUS=0x0.
REQ-029 Send 0x55 with stop bit 0 -> STATUS bit3 = 1, not_empty = 0; write 0x8 to STATUS -> bit3 cleared.
REQ-030 FIFO_EN, send 9 bytes 0x01..0x09 without reads -> STATUS=0x7; eight reads return 0x01..0x08.
REQ-031 Reset pulsed during DATA of byte 0xA5 -> STATUS=0x0, PRESC reads 16, next full byte 0x3C received correctly.
REQ-032 Write PRESC with wstrb=4'b0001, data 0x0000_1234 -> PRESC reads 0x0034.
